// File: rtl/acia_tx_fifo_pkg.sv
// Shared encodings and frame-timing helpers for the ACIA transmit path.
package acia_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

  localparam logic [1:0] WL_8 = 2'b00;
  localparam logic [1:0] WL_7 = 2'b01;
  localparam logic [1:0] WL_6 = 2'b10;
  localparam logic [1:0] WL_5 = 2'b11;

  localparam logic [1:0] PMC_ODD   = 2'b00;
  localparam logic [1:0] PMC_EVEN  = 2'b01;
  localparam logic [1:0] PMC_MARK  = 2'b10;
  localparam logic [1:0] PMC_SPACE = 2'b11;

  // Index of the last data bit sent for a given word-length code.
  function automatic logic [2:0] data_last_bit(input logic [1:0] wl);
    logic [2:0] last;
    last = 3'd7;
    case (wl)
      WL_8: last = 3'd7;
      WL_7: last = 3'd6;
      WL_6: last = 3'd5;
      WL_5: last = 3'd4;
      default: last = 3'd7;
    endcase
    return last;
  endfunction

  // Stop field length in baud ticks; the 1.5-bit case only exists for 5-bit words.
  function automatic int stop_ticks(input logic [1:0] wl, input logic pme,
                                    input logic sbn, input int os);
    if (!sbn) return os;
    if (wl == WL_5 && !pme) return os + os / 2;
    if (wl == WL_8 && pme) return os;
    return 2 * os;
  endfunction

  function automatic logic frame_parity(input logic [7:0] data, input logic [1:0] wl,
                                        input logic [1:0] pmc);
    logic x;
    logic p;
    x = ^(data & (8'hFF >> wl));
    p = 1'b0;
    case (pmc)
      PMC_ODD:   p = ~x;
      PMC_EVEN:  p = x;
      PMC_MARK:  p = 1'b1;
      PMC_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/acia_tx_fifo_mem.sv
// Transmit byte queue: storage, wrapping pointers, occupancy and sticky overrun.
module acia_tx_fifo_mem #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_i,
  input  logic [7:0]               wdata_i,
  input  logic                     rd_i,
  output logic [7:0]               rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          ovr_q;
  logic          wr_ok, rd_ok;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign ovr_o   = ovr_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign wr_ok = wr_i & ~full_o;
  assign rd_ok = rd_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (wr_ok)     ovr_q <= 1'b0;
      else if (wr_i) ovr_q <= 1'b1;
    end
  end

endmodule

// File: rtl/acia_tx_fifo.sv
// ACIA transmitter: byte FIFO feeding an oversampled async serialiser with parity and break.
module acia_tx_fifo
  import acia_tx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          phi2_i,
  input  logic                          reset_ni,
  input  logic                          bclk_en_i,
  input  logic                          ctsb_i,
  input  logic [7:0]                    txdata_i,
  input  logic                          txlatch_i,
  input  logic [1:0]                    r_wl_i,
  input  logic                          r_pme_i,
  input  logic [1:0]                    r_pmc_i,
  input  logic                          r_sbn_i,
  input  logic                          r_brk_i,
  output logic                          tx_o,
  output logic                          txfull_o,
  output logic                          txempty_o,
  output logic [$clog2(FIFO_DEPTH):0]   txlevel_o,
  output logic                          txovr_o
);

  localparam int CW = $clog2(2 * OVERSAMPLE);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    wl_q, wl_d;
  logic          pme_q, pme_d, sbn_q, sbn_d, par_q, par_d, tx_q, tx_d;

  logic       pop, fifo_empty, bit_end, stop_end, can_start, launch;
  logic [7:0] head;

  acia_tx_fifo_mem #(.DEPTH(FIFO_DEPTH)) u_mem (
    .clk_i   (phi2_i),
    .rst_ni  (reset_ni),
    .wr_i    (txlatch_i),
    .wdata_i (txdata_i),
    .rd_i    (pop),
    .rdata_o (head),
    .level_o (txlevel_o),
    .full_o  (txfull_o),
    .empty_o (fifo_empty),
    .ovr_o   (txovr_o)
  );

  assign bit_end   = (cnt_q == CW'(OVERSAMPLE - 1));
  assign stop_end  = (cnt_q == CW'(stop_ticks(wl_q, pme_q, sbn_q, OVERSAMPLE) - 1));
  assign can_start = !fifo_empty && !ctsb_i && !r_brk_i;
  // The final stop tick doubles as the idle decision so queued frames run back to back.
  assign launch    = bclk_en_i && can_start &&
                     (state_q == ST_IDLE || (state_q == ST_STOP && stop_end));

  assign tx_o      = tx_q;
  assign txempty_o = fifo_empty && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wl_d    = wl_q;
    pme_d   = pme_q;
    sbn_d   = sbn_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (bclk_en_i) begin
      unique case (state_q)
        ST_IDLE: if (r_brk_i) begin
          state_d = ST_BREAK;
          tx_d    = 1'b0;
        end
        ST_START: if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else cnt_d = cnt_q + 1'b1;
        ST_DATA: if (bit_end) begin
          cnt_d = '0;
          if (bit_q == data_last_bit(wl_q)) begin
            state_d = pme_q ? ST_PARITY : ST_STOP;
            tx_d    = pme_q ? par_q : 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else cnt_d = cnt_q + 1'b1;
        ST_PARITY: if (bit_end) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
        ST_STOP: if (stop_end) begin
          cnt_d   = '0;
          state_d = r_brk_i ? ST_BREAK : ST_IDLE;
          tx_d    = !r_brk_i;
        end else cnt_d = cnt_q + 1'b1;
        ST_BREAK: if (!r_brk_i) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
      // Frame settings are captured here so register writes mid-frame have no effect.
      if (launch) begin
        pop     = 1'b1;
        state_d = ST_START;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
        shift_d = head;
        wl_d    = r_wl_i;
        pme_d   = r_pme_i;
        sbn_d   = r_sbn_i;
        par_d   = frame_parity(head, r_wl_i, r_pmc_i);
      end
    end
  end

  always_ff @(posedge phi2_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wl_q    <= WL_8;
      pme_q   <= 1'b0;
      sbn_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wl_q    <= wl_d;
      pme_q   <= pme_d;
      sbn_q   <= sbn_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_acia_tx_fifo.sv
// Directed bench: expected line levels are queued per tick at write time and checked as TX runs.
module tb_acia_tx_fifo;

  localparam int DEPTH = 4;
  localparam int OS    = 16;

  logic       phi2, rst_n, bclk_en, ctsb, txlatch, r_pme, r_sbn, r_brk;
  logic [7:0] txdata;
  logic [1:0] r_wl, r_pmc;
  logic       tx, txfull, txempty, txovr;
  logic [2:0] txlevel;

  typedef struct {
    logic v;
    bit   last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   frames_done = 0;
  int   pos = 0;
  bit   in_frame = 0;
  bit   hold = 0;
  bit   b2b = 0;

  acia_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .phi2_i    (phi2),
    .reset_ni  (rst_n),
    .bclk_en_i (bclk_en),
    .ctsb_i    (ctsb),
    .txdata_i  (txdata),
    .txlatch_i (txlatch),
    .r_wl_i    (r_wl),
    .r_pme_i   (r_pme),
    .r_pmc_i   (r_pmc),
    .r_sbn_i   (r_sbn),
    .r_brk_i   (r_brk),
    .tx_o      (tx),
    .txfull_o  (txfull),
    .txempty_o (txempty),
    .txlevel_o (txlevel),
    .txovr_o   (txovr)
  );

  initial begin
    phi2 = 1'b0;
    forever #5 phi2 = ~phi2;
  end

  initial begin
    bclk_en = 1'b0;
    forever begin
      @(negedge phi2);
      bclk_en = ~bclk_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic bv, input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) exp_q.push_back('{v: bv, last: (last_at_end && i == n - 1)});
  endtask

  task automatic push_frame(input logic [7:0] d);
    int   nb, sl;
    logic x, p;
    nb = 8 - int'(r_wl);
    x  = 1'b0;
    p  = 1'b0;
    push_bits(1'b0, OS, 1'b0);
    for (int i = 0; i < nb; i++) begin
      push_bits(d[i], OS, 1'b0);
      x = x ^ d[i];
    end
    if (r_pme) begin
      case (r_pmc)
        2'b00:   p = ~x;
        2'b01:   p = x;
        2'b10:   p = 1'b1;
        default: p = 1'b0;
      endcase
      push_bits(p, OS, 1'b0);
    end
    if (!r_sbn)                 sl = OS;
    else if (nb == 5 && !r_pme) sl = OS * 3 / 2;
    else if (nb == 8 && r_pme)  sl = OS;
    else                        sl = 2 * OS;
    push_bits(1'b1, sl, 1'b1);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept);
    @(negedge phi2);
    txdata  = d;
    txlatch = 1'b1;
    if (accept) push_frame(d);
    @(negedge phi2);
    txlatch = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] wl, input logic pme, input logic [1:0] pmc,
                         input logic sbn);
    @(negedge phi2);
    r_wl  = wl;
    r_pme = pme;
    r_pmc = pmc;
    r_sbn = sbn;
  endtask

  task automatic wait_tick();
    do @(posedge phi2); while (bclk_en !== 1'b1);
    #1;
  endtask

  task automatic wait_frames(input int target, input string tag);
    for (int i = 0; i < 6000 && frames_done < target; i++) @(negedge phi2);
    check(tag, 32'(frames_done >= target), 1);
  endtask

  task automatic wait_pos(input int n, input string tag);
    for (int i = 0; i < 3000 && !(in_frame && pos >= n); i++) @(negedge phi2);
    check(tag, 32'(in_frame && pos >= n), 1);
  endtask

  // Line monitor: one expected level consumed per tick while a frame is in flight.
  initial begin
    exp_t e;
    forever begin
      @(posedge phi2);
      if (bclk_en && rst_n) begin
        #1;
        if (!in_frame && !hold && tx === 1'b0 && exp_q.size() > 0) begin
          in_frame = 1'b1;
          pos      = 0;
        end
        if (in_frame) begin
          e = exp_q.pop_front();
          check($sformatf("tx_bit@%0d", pos), 32'(tx), 32'(e.v));
          pos++;
          if (e.last) begin
            frames_done++;
            pos = 0;
            if (!(b2b && exp_q.size() > 0)) in_frame = 1'b0;
          end
        end else if (!hold) begin
          check("tx_idle", 32'(tx), 1);
        end
      end
    end
  end

  initial begin
    int target;
    rst_n = 1'b1; ctsb = 1'b1; txlatch = 1'b0; txdata = 8'h00;
    r_wl = 2'b00; r_pme = 1'b0; r_pmc = 2'b00; r_sbn = 1'b0; r_brk = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_full", 32'(txfull), 0);
    check("rst_empty", 32'(txempty), 1);
    check("rst_level", 32'(txlevel), 0);
    check("rst_ovr", 32'(txovr), 0);
    repeat (3) @(negedge phi2);
    rst_n = 1'b1;

    // 8N1 0xA5: 160 ticks then empty
    ctsb = 1'b0;
    target = frames_done + 1;
    write_byte(8'hA5, 1'b1);
    wait_frames(target, "8n1_done");
    wait_tick();
    check("8n1_empty", 32'(txempty), 1);

    // 7E2 0x7F, registers changed mid-frame must not matter
    set_cfg(2'b01, 1'b1, 2'b01, 1'b1);
    target = frames_done + 1;
    write_byte(8'h7F, 1'b1);
    wait_pos(20, "7e2_pos");
    set_cfg(2'b00, 1'b0, 2'b00, 1'b0);
    wait_frames(target, "7e2_done");
    wait_tick();
    check("7e2_empty", 32'(txempty), 1);

    // 5N1.5 0x1F, high bits ignored via 0xFF upper
    set_cfg(2'b11, 1'b0, 2'b00, 1'b1);
    target = frames_done + 1;
    write_byte(8'hFF, 1'b1);
    wait_frames(target, "5n15_done");
    wait_tick();
    check("5n15_empty", 32'(txempty), 1);

    // 8O with SBN=1 keeps one stop bit
    set_cfg(2'b00, 1'b1, 2'b00, 1'b1);
    target = frames_done + 1;
    write_byte(8'h03, 1'b1);
    wait_frames(target, "8o_done");
    wait_tick();
    check("8o_empty", 32'(txempty), 1);

    // 6-bit mark parity
    set_cfg(2'b10, 1'b1, 2'b10, 1'b0);
    target = frames_done + 1;
    write_byte(8'hC0, 1'b1);
    wait_frames(target, "6m_done");
    wait_tick();
    check("6m_empty", 32'(txempty), 1);

    // Fill with CTSB high, overrun, then drain back to back
    set_cfg(2'b00, 1'b0, 2'b00, 1'b0);
    ctsb = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'(8'h11 * (i + 1)), 1'b1);
      check($sformatf("fill_level%0d", i), 32'(txlevel), 32'(i + 1));
    end
    check("fill_full", 32'(txfull), 1);
    write_byte(8'h55, 1'b0);
    check("ovr_set", 32'(txovr), 1);
    check("ovr_level", 32'(txlevel), DEPTH);
    b2b = 1'b1;
    target = frames_done + DEPTH;
    @(negedge phi2);
    ctsb = 1'b0;
    wait_frames(target, "b2b_done");
    wait_tick();
    check("b2b_empty", 32'(txempty), 1);
    b2b = 1'b0;
    check("ovr_sticky", 32'(txovr), 1);
    ctsb = 1'b1;
    write_byte(8'h96, 1'b1);
    check("ovr_clear", 32'(txovr), 0);
    check("ovr_clr_level", 32'(txlevel), 1);
    target = frames_done + 1;
    ctsb = 1'b0;
    wait_frames(target, "ovr_drain");
    wait_tick();
    check("ovr_drain_empty", 32'(txempty), 1);

    // Break mid-frame: frame finishes, line held low, queued byte resumes
    ctsb = 1'b1;
    write_byte(8'h3C, 1'b1);
    write_byte(8'hC3, 1'b1);
    target = frames_done + 1;
    ctsb = 1'b0;
    wait_pos(50, "brk_pos");
    r_brk = 1'b1;
    hold  = 1'b1;
    wait_frames(target, "brk_frame");
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      check($sformatf("brk_tx%0d", i), 32'(tx), 0);
    end
    check("brk_notempty", 32'(txempty), 0);
    check("brk_level", 32'(txlevel), 1);
    @(negedge phi2);
    r_brk = 1'b0;
    hold  = 1'b0;
    target = frames_done + 1;
    wait_frames(target, "brk_resume");
    wait_tick();
    check("brk_empty", 32'(txempty), 1);

    // Asynchronous reset during a data bit
    ctsb = 1'b1;
    write_byte(8'h00, 1'b1);
    write_byte(8'h5A, 1'b1);
    ctsb = 1'b0;
    wait_pos(40, "rst_pos");
    @(negedge phi2);
    check("pre_rst_tx", 32'(tx), 0);
    check("pre_rst_level", 32'(txlevel), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_level", 32'(txlevel), 0);
    check("mid_rst_empty", 32'(txempty), 1);
    exp_q.delete();
    in_frame = 1'b0;
    pos = 0;
    repeat (2) @(negedge phi2);
    rst_n = 1'b1;
    repeat (6) wait_tick();
    check("post_rst_level", 32'(txlevel), 0);
    check("post_rst_empty", 32'(txempty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/acia_tx_fifo.md
ACIA_TX_FIFO -- requirements
Module: acia_tx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning: transmit FIFO entries, power of two, 2..16.
REQ-002 Parameter OVERSAMPLE, default 16, meaning: baud ticks per bit, 8..64.
REQ-003 PHI2  in  1  sole clock, all state on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 BCLK_EN  in  1  baud tick enable, one PHI2 cycle wide.
REQ-006 CTSB  in  1  clear-to-send, active low.
REQ-007 TXDATA  in  8  byte to enqueue.
REQ-008 TXLATCH  in  1  write strobe, one PHI2 cycle.
REQ-009 R_WL  in  2  word length: 00=8, 01=7, 10=6, 11=5 bits.
REQ-010 R_PME  in  1  parity enable.
REQ-011 R_PMC  in  2  parity mode: 00 odd, 01 even, 10 mark, 11 space.
REQ-012 R_SBN  in  1  extra stop bit select.
REQ-013 R_BRK  in  1  break request.
REQ-014 TX  out  1  serial line.
REQ-015 TXFULL  out  1  FIFO full.
REQ-016 TXEMPTY  out  1  FIFO empty AND serialiser idle.
REQ-017 TXLEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-018 TXOVR  out  1  sticky overrun flag.

Function
REQ-019 TXLATCH with TXFULL=0 SHALL write TXDATA at the tail; TXFULL/TXLEVEL update next cycle.
REQ-020 TXLATCH with TXFULL=1 SHALL be discarded and set TXOVR, even if a pop occurs in the same cycle.
REQ-021 TXOVR SHALL clear on the next accepted write.
REQ-022 Simultaneous accepted write and pop SHALL leave TXLEVEL unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; all transitions occur only on BCLK_EN cycles.
REQ-024 In IDLE on a tick with TXLEVEL>0, CTSB=0 and R_BRK=0: pop the head, latch R_WL/R_PME/R_PMC/R_SBN for the frame, drive TX=0, go to START.
REQ-025 Each bit SHALL last exactly OVERSAMPLE ticks; TX changes only on tick cycles.
REQ-026 DATA SHALL send LSB first, 5..8 bits per the latched R_WL; unused high bits are ignored.
REQ-027 Parity SHALL be computed over transmitted bits only; odd -> XOR inverted, even -> XOR, mark -> 1, space -> 0.
REQ-028 STOP SHALL hold TX=1 for 1 bit if R_SBN=0.
REQ-029 With R_SBN=1, STOP SHALL last 2 bits, except 1.5 bits for 5-bit without parity and 1 bit for 8-bit with parity.
REQ-030 After STOP, the FSM SHALL return to IDLE; a queued byte starts on the next tick (no extra idle bit).
REQ-031 Deassertion of CTSB mid-frame SHALL NOT abort the frame; CTSB is sampled only in IDLE.
REQ-032 R_BRK=1 in IDLE on a tick SHALL enter BREAK with TX=0 and no pop.
REQ-033 BREAK SHALL exit to IDLE on the first tick with R_BRK=0, driving TX=1.
REQ-034 R_BRK asserted mid-frame SHALL take effect only after STOP completes.
REQ-035 Register changes mid-frame SHALL NOT affect the current frame.

Reset
REQ-036 RESET low SHALL immediately set TX=1, TXFULL=0, TXEMPTY=1, TXLEVEL=0, TXOVR=0, FSM=IDLE, pointers and counters 0.
REQ-037 Reset mid-frame SHALL abort the frame and flush the FIFO; FIFO storage contents need not be cleared.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding, the R_WL and R_PMC code constants, and the stop-length tick computation function.
REQ-039 The FIFO SHALL be a separate sub-module acia_tx_fifo_mem (storage, pointers, level, full/empty); the FSM, bit counter and tick counter stay in the top.

Verification
REQ-040 Scenario: OVERSAMPLE=16; 8N1; write 0xA5, CTSB=0 -> TX sequence 0,1,0,1,0,0,1,0,1,1, 16 ticks each, 160 ticks total, then TXEMPTY=1.
REQ-041 Scenario: 7-bit, even parity, R_SBN=1; write 0x7F -> seven 1s, parity 1, two stop bits, 176 ticks total.
REQ-042 Scenario: 5-bit, no parity, R_SBN=1; write 0x1F -> stop field 24 ticks, frame 120 ticks.
REQ-043 Scenario: FIFO_DEPTH=4, CTSB=1; write 5 bytes -> TXLEVEL=4, TXFULL=1, TXOVR=1.
REQ-044 Scenario (continues REQ-043): drop CTSB -> 4 back-to-back frames with no gap, TXEMPTY=1 after the last stop.
REQ-045 Scenario: assert R_BRK mid-frame -> current frame completes, TX held 0 until R_BRK=0, then queued data resumes.
REQ-046 Scenario: assert RESET low mid DATA bit -> TX=1 and TXLEVEL=0 in the same cycle.
